seq_chk: RTL and testbench
==========================

# seq_chk

Sequence checker that consumes the 4-bit count-run stream produced by the sequence generator. In that stream each value v from 1 to MAX_VAL is repeated v times, then the stream wraps back to 1. The checker sits on the generator output in test and bring-up builds. It hunts for the start of a period, locks, compares every valid sample against the expected value, and reports mismatches and completed periods through registered flags and saturating counters.

## Interface
- MAX_VAL, default 9: highest value in the stream. Legal range is 2..15. One period is MAX_VAL*(MAX_VAL+1)/2 samples.
- CNT_W, default 8: width of err_cnt and period_cnt.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. It is sampled on the rising edge of clk.
- in_valid  input  1  qualifies in_data. Cycles with in_valid=0 are ignored entirely.
- in_data  input  4  stream sample.
- locked  output  1  high while in TRACK.
- exp_data  output  4  value expected on the next valid sample. It is 0 when not locked.
- err  output  1  one-cycle pulse on a mismatch.
- err_cnt  output  CNT_W  mismatch count. Saturates at all-ones.
- period_done  output  1  one-cycle pulse when a full period has matched.
- period_cnt  output  CNT_W  completed-period count. Saturates at all-ones.

## Operation
- Internal registers:
  - cur: 4-bit current run value.
  - run: 4-bit number of samples of cur seen so far.
  - prev: 4-bit last valid in_data.
  - state: HUNT or TRACK.
- Next-expected value:
  - nxt = cur when run < cur.
  - Otherwise nxt = (cur == MAX_VAL) ? 1 : cur+1.
- Every valid sample updates prev <= in_data, in both states.
- HUNT state:
  - A valid sample with in_data==1 and prev!=1 moves to TRACK, with cur=1 and run=1.
  - Any other valid sample stays in HUNT. It does not count as an error.
- TRACK state, valid sample with in_data==nxt (match):
  - If nxt==cur, then run <= run+1.
  - Otherwise cur <= nxt and run <= 1.
  - The match that completes the last MAX_VAL sample (cur==MAX_VAL and run reaches MAX_VAL) pulses period_done and increments period_cnt.
- TRACK state, valid sample with in_data!=nxt (mismatch):
  - err pulses and err_cnt increments.
  - The next state depends on the Configuration macro.
- exp_data is a registered output. It equals nxt computed from the post-update cur/run while in TRACK, and 0 in HUNT.
- Both counters saturate: once at all-ones they hold and never wrap.
- Mid-run entry: a stream that starts mid-period stays in HUNT until the first 1 that follows a non-1 sample. Leading 0s from the generator are ignored in the same way.
- Out-of-range data (0, or >MAX_VAL) in TRACK is an ordinary mismatch.

## Timing
- All outputs are registered.
- err, period_done, counter updates, locked and exp_data change on the clock edge that samples the causing input. They are visible the cycle after in_valid is presented.
- err and period_done are single-cycle pulses. They never assert when in_valid=0 in the previous cycle.
- Reset values:
  - locked=0, exp_data=0, err=0, err_cnt=0, period_done=0, period_cnt=0.
  - Internal: state=HUNT, cur=0, run=0, prev=0.
- Reset mid-operation:
  - Reset overrides any sample on the same edge.
  - All outputs read their reset values the cycle after rst is sampled high.
- Simultaneous saturated error: err still pulses, and err_cnt holds at all-ones.

## Configuration
- SEQ_CHK_RESYNC_EN defined:
  - A mismatching sample with in_data==1 immediately restarts tracking (cur=1, run=1, state stays TRACK, locked stays 1), and err still pulses.
  - Other mismatches go to HUNT.
- SEQ_CHK_RESYNC_EN undefined:
  - Every mismatch goes to HUNT and locked falls.
  - The mismatching sample cannot itself start a new lock.

## Test plan
- Basic lock and period:
  - Stimulus: after reset, stream 0,1,2,2,3,3,3,…,9×9,1 with in_valid=1.
  - Response: locked rises the cycle after the first 1, and exp_data=2.
  - period_done pulses once after the 45th tracked sample, period_cnt=1, err_cnt=0.
- Single corruption:
  - Stimulus: replace the third 3 with 4.
  - Response: err pulses once, err_cnt=1, locked=0.
  - Relock occurs on the 1 that follows the 9-run, and period_cnt is unchanged for the broken period.
- Valid gaps:
  - Stimulus: drop in_valid for 3 cycles in the middle of the 5-run, with in_data=X.
  - Response: no err, exp_data holds 5, and the period completes normally.
- Counter saturation:
  - Stimulus: with CNT_W=8, force 300 mismatches (relock, then corrupt, repeated).
  - Response: err_cnt=255, and err still pulses on each mismatch.
- Resync macro:
  - Stimulus: in the 5-run, inject a 1 followed by 2,2.
  - Response with SEQ_CHK_RESYNC_EN defined: err pulses, locked stays 1, exp_data=2 after the 1, and no further error.
  - Response with the macro undefined: locked=0, and the stream stays in HUNT until the next period start.
- Reset mid-TRACK:
  - Stimulus: assert rst for 1 cycle during the 7-run.
  - Response: all outputs read 0 the next cycle.
  - A subsequent 1 (prev cleared to 0) relocks immediately.

Source files
------------

// File: rtl/seq_chk.sv
// Count-run stream checker: hunts for a period start, locks, and flags mismatches/completed periods.
// Optional SEQ_CHK_RESYNC_EN: a mismatching 1 restarts tracking instead of dropping to HUNT.
module seq_chk #(
  parameter int MAX_VAL = 9,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             locked,
  output logic [3:0]       exp_data,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             period_done,
  output logic [CNT_W-1:0] period_cnt
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [3:0] MAXV = 4'(MAX_VAL);

  // Value expected after having seen r samples of run value c.
  function automatic logic [3:0] nxt_f(input logic [3:0] c, input logic [3:0] r);
    if (r < c)          return c;
    else if (c == MAXV) return 4'd1;
    else                return c + 4'd1;
  endfunction

  state_t           state, state_d;
  logic [3:0]       cur, cur_d, run, run_d, prev, prev_d, exp_d, nxt;
  logic             err_d, pd_d;
  logic [CNT_W-1:0] err_cnt_d, period_cnt_d;

  assign nxt    = nxt_f(cur, run);
  assign locked = (state == TRACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cur         <= '0;
      run         <= '0;
      prev        <= '0;
      exp_data    <= '0;
      err         <= 1'b0;
      period_done <= 1'b0;
      err_cnt     <= '0;
      period_cnt  <= '0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      run         <= run_d;
      prev        <= prev_d;
      exp_data    <= exp_d;
      err         <= err_d;
      period_done <= pd_d;
      err_cnt     <= err_cnt_d;
      period_cnt  <= period_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    cur_d        = cur;
    run_d        = run;
    prev_d       = prev;
    err_d        = 1'b0;
    pd_d         = 1'b0;
    err_cnt_d    = err_cnt;
    period_cnt_d = period_cnt;
    if (in_valid) begin
      prev_d = in_data;
      case (state)
        HUNT: begin
          // A period start is a 1 that follows anything other than a 1.
          if (in_data == 4'd1 && prev != 4'd1) begin
            state_d = TRACK;
            cur_d   = 4'd1;
            run_d   = 4'd1;
          end
        end
        TRACK: begin
          if (in_data == nxt) begin
            if (nxt == cur) begin
              run_d = run + 4'd1;
            end else begin
              cur_d = nxt;
              run_d = 4'd1;
            end
            if (cur_d == MAXV && run_d == MAXV) begin
              pd_d = 1'b1;
              if (period_cnt != '1) period_cnt_d = period_cnt + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (err_cnt != '1) err_cnt_d = err_cnt + CNT_W'(1);
`ifdef SEQ_CHK_RESYNC_EN
            if (in_data == 4'd1) begin
              cur_d = 4'd1;
              run_d = 4'd1;
            end else begin
              state_d = HUNT;
              cur_d   = '0;
              run_d   = '0;
            end
`else
            state_d = HUNT;
            cur_d   = '0;
            run_d   = '0;
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end
    exp_d = (state_d == TRACK) ? nxt_f(cur_d, run_d) : 4'd0;
  end

endmodule

// File: tb/tb_seq_chk.sv
// Bench for seq_chk: period-position reference model feeds a scoreboard, plus per-test spot checks.
module tb_seq_chk;
  localparam int MAXV = 9;
  localparam int PLEN = MAXV * (MAXV + 1) / 2;

  logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       locked, err, period_done;
  logic [3:0] exp_data;
  logic [7:0] err_cnt, period_cnt;

  seq_chk #(.MAX_VAL(MAXV), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .exp_data(exp_data), .err(err), .err_cnt(err_cnt),
    .period_done(period_done), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic [3:0] ex;
    logic       er;
    logic [7:0] ec;
    logic       pd;
    logic [7:0] pc;
  } obs_t;

  obs_t       sbq[$];
  int         compared = 0, mismatched = 0;
  int         seq[PLEN];
  bit         m_lock;
  int         m_pos;
  logic [3:0] m_prev;
  logic [7:0] m_ec, m_pc;
  obs_t       m_exp;

  // Reference: position within the golden period table.
  task automatic model_step(input logic r, input logic v, input logic [3:0] d);
    m_exp.er = 1'b0;
    m_exp.pd = 1'b0;
    if (r) begin
      m_lock = 0; m_pos = 0; m_prev = 0; m_ec = 0; m_pc = 0;
    end else if (v) begin
      if (!m_lock) begin
        if (d == 4'd1 && m_prev != 4'd1) begin m_lock = 1; m_pos = 1; end
      end else if (int'(d) == seq[m_pos]) begin
        m_pos++;
        if (m_pos == PLEN) begin
          m_pos = 0;
          m_exp.pd = 1'b1;
          if (m_pc != 8'hff) m_pc++;
        end
      end else begin
        m_exp.er = 1'b1;
        if (m_ec != 8'hff) m_ec++;
`ifdef SEQ_CHK_RESYNC_EN
        if (d == 4'd1) m_pos = 1;
        else m_lock = 0;
`else
        m_lock = 0;
`endif
      end
      m_prev = d;
    end
    m_exp.lk = m_lock;
    m_exp.ex = m_lock ? 4'(seq[m_pos]) : 4'd0;
    m_exp.ec = m_ec;
    m_exp.pc = m_pc;
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] d);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d;
    model_step(r, v, d);
    @(posedge clk);
    sbq.push_back(m_exp);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(1'b0, 1'b1, 4'(seq[i]));
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {locked, exp_data, err, err_cnt, period_done, period_cnt};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL sb t=%0t got lk=%0b ex=%0d er=%0b ec=%0d pd=%0b pc=%0d want lk=%0b ex=%0d er=%0b ec=%0d pd=%0b pc=%0d",
                 $time, a.lk, a.ex, a.er, a.ec, a.pd, a.pc, e.lk, e.ex, e.er, e.ec, e.pd, e.pc);
      end
    end
  end

  task automatic test_reset;
    drive(1'b1, 1'b1, 4'd1);
    compared++;
    if ({locked, exp_data, err, err_cnt, period_done, period_cnt} !== 23'd0) begin
      mismatched++;
      $display("FAIL reset got lk=%0b ex=%0d er=%0b ec=%0d pd=%0b pc=%0d want all 0",
               locked, exp_data, err, err_cnt, period_done, period_cnt);
    end
  endtask

  task automatic test_basic;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 4'd1);
    compared++;
    if (locked !== 1'b1 || exp_data !== 4'd2) begin
      mismatched++; $display("FAIL basic_lock got lk=%0b ex=%0d want lk=1 ex=2", locked, exp_data);
    end
    send_range(1, PLEN - 1);
    compared++;
    if (period_done !== 1'b1 || period_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL basic_period got pd=%0b pc=%0d ec=%0d want pd=1 pc=1 ec=0", period_done, period_cnt, err_cnt);
    end
    drive(1'b0, 1'b1, 4'd1);
    compared++;
    if (period_done !== 1'b0 || locked !== 1'b1 || exp_data !== 4'd2) begin
      mismatched++;
      $display("FAIL basic_wrap got pd=%0b lk=%0b ex=%0d want pd=0 lk=1 ex=2", period_done, locked, exp_data);
    end
  endtask

  task automatic test_corrupt;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    send_range(0, 4);
    drive(1'b0, 1'b1, 4'd4);
    compared++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
      mismatched++; $display("FAIL corrupt_err got er=%0b ec=%0d lk=%0b want er=1 ec=1 lk=0", err, err_cnt, locked);
    end
    send_range(6, PLEN - 1);
    compared++;
    if (locked !== 1'b0 || period_cnt !== 8'd0) begin
      mismatched++; $display("FAIL corrupt_hunt got lk=%0b pc=%0d want lk=0 pc=0", locked, period_cnt);
    end
    send_range(0, PLEN - 1);
    compared++;
    if (period_cnt !== 8'd1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
      mismatched++; $display("FAIL corrupt_relock got pc=%0d ec=%0d lk=%0b want pc=1 ec=1 lk=1", period_cnt, err_cnt, locked);
    end
  endtask

  task automatic test_gaps;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    send_range(0, 12);
    repeat (3) drive(1'b0, 1'b0, 4'bxxxx);
    compared++;
    if (exp_data !== 4'd5 || err !== 1'b0 || locked !== 1'b1) begin
      mismatched++; $display("FAIL gap_hold got ex=%0d er=%0b lk=%0b want ex=5 er=0 lk=1", exp_data, err, locked);
    end
    send_range(13, PLEN - 1);
    compared++;
    if (period_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      mismatched++; $display("FAIL gap_period got pc=%0d ec=%0d want pc=1 ec=0", period_cnt, err_cnt);
    end
  endtask

  task automatic test_saturation;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    repeat (300) begin
      drive(1'b0, 1'b1, 4'd1);
      drive(1'b0, 1'b1, 4'd5);
    end
    compared++;
    if (err_cnt !== 8'hff || err !== 1'b1) begin
      mismatched++; $display("FAIL saturate got ec=%0d er=%0b want ec=255 er=1", err_cnt, err);
    end
  endtask

  task automatic test_resync;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    send_range(0, 11);
    drive(1'b0, 1'b1, 4'd1);
    compared++;
`ifdef SEQ_CHK_RESYNC_EN
    if (err !== 1'b1 || locked !== 1'b1 || exp_data !== 4'd2) begin
      mismatched++; $display("FAIL resync_one got er=%0b lk=%0b ex=%0d want er=1 lk=1 ex=2", err, locked, exp_data);
    end
`else
    if (err !== 1'b1 || locked !== 1'b0 || exp_data !== 4'd0) begin
      mismatched++; $display("FAIL resync_one got er=%0b lk=%0b ex=%0d want er=1 lk=0 ex=0", err, locked, exp_data);
    end
`endif
    drive(1'b0, 1'b1, 4'd2);
    drive(1'b0, 1'b1, 4'd2);
    send_range(3, PLEN - 1);
    compared++;
`ifdef SEQ_CHK_RESYNC_EN
    if (err_cnt !== 8'd1 || period_cnt !== 8'd1 || locked !== 1'b1) begin
      mismatched++; $display("FAIL resync_run got ec=%0d pc=%0d lk=%0b want ec=1 pc=1 lk=1", err_cnt, period_cnt, locked);
    end
`else
    if (err_cnt !== 8'd1 || period_cnt !== 8'd0 || locked !== 1'b0) begin
      mismatched++; $display("FAIL resync_run got ec=%0d pc=%0d lk=%0b want ec=1 pc=0 lk=0", err_cnt, period_cnt, locked);
    end
`endif
    drive(1'b0, 1'b1, 4'd1);
    compared++;
    if (locked !== 1'b1 || exp_data !== 4'd2) begin
      mismatched++; $display("FAIL resync_next got lk=%0b ex=%0d want lk=1 ex=2", locked, exp_data);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    send_range(0, 23);
    drive(1'b1, 1'b1, 4'd7);
    compared++;
    if ({locked, exp_data, err, err_cnt, period_done, period_cnt} !== 23'd0) begin
      mismatched++;
      $display("FAIL reset_mid got lk=%0b ex=%0d er=%0b ec=%0d pd=%0b pc=%0d want all 0",
               locked, exp_data, err, err_cnt, period_done, period_cnt);
    end
    drive(1'b0, 1'b1, 4'd1);
    compared++;
    if (locked !== 1'b1 || exp_data !== 4'd2) begin
      mismatched++; $display("FAIL reset_relock got lk=%0b ex=%0d want lk=1 ex=2", locked, exp_data);
    end
  endtask

  initial begin
    int k;
    k = 0;
    for (int v = 1; v <= MAXV; v++)
      for (int j = 0; j < v; j++) begin seq[k] = v; k++; end
    m_lock = 0; m_pos = 0; m_prev = 0; m_ec = 0; m_pc = 0;
    test_reset();
    test_basic();
    test_corrupt();
    test_gaps();
    test_saturation();
    test_resync();
    test_reset_mid();
    repeat (3) @(negedge clk);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++; $display("FAIL sb_drain got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
